note_player_ctrl: RTL and testbench

Sequencer that drives one sine_reader for a single note.
- Accepts a note/duration command and fetches the note's step size from the external frequency ROM.
- Paces sine_reader with one generate_next per codec sample strobe and forwards the returned samples.
- Counts beats for the note duration and pulses done_with_note when the duration expires.
- Sits between the song reader/chord logic and the sine_reader/codec path.

---
 rtl/note_player_ctrl.sv | 165 ++++++++++++++++
 tb/tb_note_player_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player_ctrl.sv
// note_player_ctrl: sequences one sine_reader for a single note.
//   Accepts a note/duration command, fetches the note's step size from the
//   external frequency ROM, paces the sine_reader with one generate_next per
//   codec sample strobe, forwards returned samples and counts beats until the
//   note duration expires.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   play_enable         1 = play, 0 = pause
//   load_new_note       command strobe; note/duration sampled with it
//   beat                one-cycle beat strobe
//   new_sample_ready    one-cycle codec sample strobe
//   rom_addr / rom_step frequency ROM address / data (data 1 cycle later)
//   step_size           step size handed to sine_reader
//   generate_next       request pulse to sine_reader
//   sample_ready/sample sample returned by sine_reader
//   sample_out(_valid)  registered sample and its one-cycle valid pulse
//   done_with_note      one-cycle pulse when the duration expires
//   busy                high whenever a note is in progress
//   overrun             one-cycle pulse when a sample strobe is dropped
module note_player_ctrl #(
  parameter int unsigned NOTE_W   = 6,
  parameter int unsigned DUR_W    = 6,
  parameter int unsigned STEP_W   = 20,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_enable,
  input  logic                load_new_note,
  input  logic [NOTE_W-1:0]   note,
  input  logic [DUR_W-1:0]    duration,
  input  logic                beat,
  input  logic                new_sample_ready,
  output logic [NOTE_W-1:0]   rom_addr,
  input  logic [STEP_W-1:0]   rom_step,
  output logic [STEP_W-1:0]   step_size,
  output logic                generate_next,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                done_with_note,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_e;

  state_e              state_q, state_d;
  logic [DUR_W-1:0]    rem_q, rem_d;
  logic                outstanding_q, outstanding_d;
  logic                rest_q, rest_d;
  logic [NOTE_W-1:0]   rom_addr_q, rom_addr_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                gen_q, gen_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;

  logic                beat_en;
  logic                finishing;
  logic                strobe_en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_new_note && (duration != '0))
                 state_d = (note == '0) ? PLAY : FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = PLAY;
      PLAY:    if (finishing) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    beat_en   = (state_q == PLAY) && play_enable && beat;
    finishing = beat_en && (rem_q == DUR_W'(1));
    // The final beat wins over a coincident strobe: no request, no overrun.
    strobe_en = (state_q == PLAY) && play_enable && new_sample_ready && !finishing;

    rem_d         = rem_q;
    rest_d        = rest_q;
    rom_addr_d    = rom_addr_q;
    step_d        = step_q;
    sample_d      = sample_q;
    outstanding_d = outstanding_q;

    gen_d   = strobe_en && !outstanding_q;
    ovr_d   = strobe_en && outstanding_q;
    valid_d = sample_ready && outstanding_q;
    done_d  = finishing;

    // Returned samples are accepted in any state so an in-flight request
    // still completes after pause or after the note ends.
    if (valid_d) begin
      sample_d      = rest_q ? '0 : sample;
      outstanding_d = 1'b0;
    end
    if (gen_d) outstanding_d = 1'b1;

    if ((state_q == IDLE) && load_new_note) begin
      rem_d = duration;
      if (duration == '0) begin
        done_d = 1'b1;
      end else if (note == '0) begin
        rest_d = 1'b1;
        step_d = '0;
      end else begin
        rest_d     = 1'b0;
        rom_addr_d = note;
      end
    end

    if (state_q == LOAD) step_d = rom_step;

    if (beat_en && (rem_q != '0)) rem_d = finishing ? '0 : rem_q - DUR_W'(1);

    busy             = (state_q != IDLE);
    rom_addr         = rom_addr_q;
    step_size        = step_q;
    generate_next    = gen_q;
    sample_out       = sample_q;
    sample_out_valid = valid_q;
    done_with_note   = done_q;
    overrun          = ovr_q;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q         <= '0;
      outstanding_q <= 1'b0;
      rest_q        <= 1'b0;
      rom_addr_q    <= '0;
      step_q        <= '0;
      sample_q      <= '0;
      gen_q         <= 1'b0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      ovr_q         <= 1'b0;
    end else begin
      rem_q         <= rem_d;
      outstanding_q <= outstanding_d;
      rest_q        <= rest_d;
      rom_addr_q    <= rom_addr_d;
      step_q        <= step_d;
      sample_q      <= sample_d;
      gen_q         <= gen_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      ovr_q         <= ovr_d;
    end
  end

endmodule

// File: tb/tb_note_player_ctrl.sv
`timescale 1ns/1ps
module tb_note_player_ctrl;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int STEP_W   = 20;
  localparam int SAMPLE_W = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                play_enable = 1'b0;
  logic                load_new_note = 1'b0;
  logic [NOTE_W-1:0]   note = '0;
  logic [DUR_W-1:0]    duration = '0;
  logic                beat = 1'b0;
  logic                new_sample_ready = 1'b0;
  logic [NOTE_W-1:0]   rom_addr;
  logic [STEP_W-1:0]   rom_step = '0;
  logic [STEP_W-1:0]   step_size;
  logic                generate_next;
  logic                sample_ready = 1'b0;
  logic [SAMPLE_W-1:0] sample = '0;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_valid;
  logic                done_with_note;
  logic                busy;
  logic                overrun;

  note_player_ctrl #(
    .NOTE_W  (NOTE_W),
    .DUR_W   (DUR_W),
    .STEP_W  (STEP_W),
    .SAMPLE_W(SAMPLE_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .play_enable     (play_enable),
    .load_new_note   (load_new_note),
    .note            (note),
    .duration        (duration),
    .beat            (beat),
    .new_sample_ready(new_sample_ready),
    .rom_addr        (rom_addr),
    .rom_step        (rom_step),
    .step_size       (step_size),
    .generate_next   (generate_next),
    .sample_ready    (sample_ready),
    .sample          (sample),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .done_with_note  (done_with_note),
    .busy            (busy),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  // Frequency ROM contents: step = note * 100 (note 5 -> 500).
  function automatic logic [STEP_W-1:0] rom_fn(input logic [NOTE_W-1:0] a);
    return STEP_W'(a) * STEP_W'(100);
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) rom_step <= rom_fn(rom_addr);

  int compared = 0;
  int mismatched = 0;

  // Reference model of the note player (abstract: note in progress,
  // cycles of fetch latency left, beats left, request in flight).
  bit                  m_busy, m_out, m_rest;
  int                  m_lat, m_rem;
  logic [NOTE_W-1:0]   m_addr;
  logic [STEP_W-1:0]   m_step;
  logic [SAMPLE_W-1:0] m_sample;

  // Observation counters and first trace divergence.
  int obs_gen, obs_valid, obs_done, obs_ovr, obs_valid_nz;
  int exp_gen, exp_valid, exp_done, exp_ovr;
  int trace_bad, bad_cyc, cyc;
  logic [46:0] bad_obs, bad_exp;

  // sine_reader model
  int rd_cnt = 0, rd_delay = 2;
  bit rd_pend = 0, rd_hold = 0;
  logic [SAMPLE_W-1:0] last_ret = '0;

  task automatic clear_counts();
    obs_gen = 0; obs_valid = 0; obs_done = 0; obs_ovr = 0; obs_valid_nz = 0;
    exp_gen = 0; exp_valid = 0; exp_done = 0; exp_ovr = 0;
    trace_bad = 0;
  endtask

  task automatic tick();
    bit out_before, fin, e_gen, e_val, e_done, e_ovr;
    logic [46:0] ov, ev;
    e_gen = 0; e_val = 0; e_done = 0; e_ovr = 0; fin = 0;
    if (reset) begin
      m_busy = 0; m_out = 0; m_rest = 0; m_lat = 0; m_rem = 0;
      m_addr = '0; m_step = '0; m_sample = '0;
    end else begin
      out_before = m_out;
      if (sample_ready && m_out) begin
        m_sample = m_rest ? '0 : sample;
        e_val = 1; m_out = 0;
      end
      if (!m_busy) begin
        if (load_new_note) begin
          if (duration == 0) e_done = 1;
          else begin
            m_busy = 1; m_rem = duration;
            if (note == 0) begin m_rest = 1; m_step = '0; m_lat = 0; end
            else begin m_rest = 0; m_addr = note; m_lat = 2; end
          end
        end
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) m_step = rom_fn(m_addr);
      end else begin
        fin = play_enable && beat && (m_rem == 1);
        if (play_enable && new_sample_ready && !fin) begin
          if (out_before) e_ovr = 1;
          else begin e_gen = 1; m_out = 1; end
        end
        if (play_enable && beat) begin
          if (fin) begin e_done = 1; m_busy = 0; m_rem = 0; end
          else m_rem--;
        end
      end
    end

    @(posedge clk); #1;
    cyc++;
    load_new_note = 0; beat = 0; new_sample_ready = 0; sample_ready = 0;

    if (generate_next === 1'b1) obs_gen++;
    if (sample_out_valid === 1'b1) obs_valid++;
    if (sample_out_valid === 1'b1 && sample_out !== '0) obs_valid_nz++;
    if (done_with_note === 1'b1) obs_done++;
    if (overrun === 1'b1) obs_ovr++;
    exp_gen += int'(e_gen); exp_valid += int'(e_val);
    exp_done += int'(e_done); exp_ovr += int'(e_ovr);

    ov = {generate_next, sample_out_valid, done_with_note, overrun, busy,
          rom_addr, step_size, sample_out};
    ev = {e_gen, e_val, e_done, e_ovr, m_busy, m_addr, m_step, m_sample};
    if (trace_bad == 0 && ov !== ev) begin
      trace_bad = 1; bad_cyc = cyc; bad_obs = ov; bad_exp = ev;
    end

    if (reset) begin
      rd_cnt = 0; rd_pend = 0;
    end else begin
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) rd_pend = 1;
      end
      if (generate_next === 1'b1) rd_cnt = rd_delay;
      if (rd_pend && !rd_hold) begin
        sample_ready = 1;
        sample = SAMPLE_W'($urandom_range(1, 65535));
        last_ret = sample;
        rd_pend = 0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1; rd_hold = 0; rd_delay = 2;
    ticks(2);
    reset = 0;
  endtask

  task automatic load(input int n, input int d);
    note = NOTE_W'(n); duration = DUR_W'(d); load_new_note = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_counts();
    do_reset();
    compared++; if ({generate_next, sample_out_valid, done_with_note, overrun} !== 4'b0) begin
      mismatched++; $display("FAIL reset_pulses: got %b want 0000",
        {generate_next, sample_out_valid, done_with_note, overrun}); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (step_size !== '0) begin mismatched++; $display("FAIL reset_step: got %0d want 0", step_size); end
    compared++; if (sample_out !== '0) begin mismatched++; $display("FAIL reset_sample_out: got %0d want 0", sample_out); end
    compared++; if (rom_addr !== '0) begin mismatched++; $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); end
    play_enable = 1;
    load(5, 3);
    compared++; if (rom_addr !== 6'd5) begin mismatched++; $display("FAIL fetch_rom_addr: got %0d want 5", rom_addr); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL fetch_busy: got %b want 1", busy); end
    ticks(2);
    compared++; if (step_size !== 20'd500) begin mismatched++; $display("FAIL load_step: got %0d want 500", step_size); end
  endtask

  task automatic test_play();
    clear_counts();
    rd_delay = 2;
    for (int i = 0; i < 70; i++) begin
      if (i % 20 == 0) new_sample_ready = 1;
      if (i == 25 || i == 45 || i == 65) beat = 1;
      tick();
    end
    compared++; if (obs_gen !== 4) begin mismatched++; $display("FAIL play_gen: got %0d want 4", obs_gen); end
    compared++; if (obs_valid !== 4) begin mismatched++; $display("FAIL play_valid: got %0d want 4", obs_valid); end
    compared++; if (obs_ovr !== 0) begin mismatched++; $display("FAIL play_overrun: got %0d want 0", obs_ovr); end
    compared++; if (obs_done !== 1) begin mismatched++; $display("FAIL play_done: got %0d want 1", obs_done); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL play_busy_end: got %b want 0", busy); end
    compared++; if (sample_out !== last_ret) begin mismatched++; $display("FAIL play_sample: got %0d want %0d", sample_out, last_ret); end
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL play_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask

  task automatic test_pause();
    logic [SAMPLE_W-1:0] held;
    int g0, d0;
    clear_counts();
    do_reset();
    play_enable = 1;
    load(7, 3);
    ticks(2);
    new_sample_ready = 1; tick();
    ticks(4);
    beat = 1; tick();          // 3 -> 2 beats left
    ticks(4);
    held = sample_out;
    g0 = obs_gen; d0 = obs_done;
    play_enable = 0;
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 0) new_sample_ready = 1;
      if (i == 15 || i == 35) beat = 1;
      tick();
    end
    compared++; if (obs_gen - g0 !== 0) begin mismatched++; $display("FAIL pause_gen: got %0d want 0", obs_gen - g0); end
    compared++; if (sample_out !== held) begin mismatched++; $display("FAIL pause_held: got %0d want %0d", sample_out, held); end
    compared++; if (busy !== 1'b1 || obs_done - d0 !== 0) begin mismatched++;
      $display("FAIL pause_busy: got busy=%b done=%0d want busy=1 done=0", busy, obs_done - d0); end
    play_enable = 1;
    beat = 1; tick(); ticks(3);
    compared++; if (obs_done - d0 !== 0) begin mismatched++; $display("FAIL resume_first_beat: got %0d done want 0", obs_done - d0); end
    beat = 1; tick();
    compared++; if (done_with_note !== 1'b1) begin mismatched++; $display("FAIL resume_second_beat: got %b want 1", done_with_note); end
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL pause_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask

  task automatic test_rest();
    clear_counts();
    do_reset();
    play_enable = 1;
    load(0, 2);
    compared++; if (step_size !== '0 || busy !== 1'b1) begin mismatched++;
      $display("FAIL rest_load: got step=%0d busy=%b want step=0 busy=1", step_size, busy); end
    for (int i = 0; i < 50; i++) begin
      if (i % 20 == 0) new_sample_ready = 1;
      if (i == 25 || i == 45) beat = 1;
      tick();
    end
    compared++; if (obs_valid !== 3) begin mismatched++; $display("FAIL rest_valid: got %0d want 3", obs_valid); end
    compared++; if (obs_valid_nz !== 0) begin mismatched++; $display("FAIL rest_zero: got %0d nonzero want 0", obs_valid_nz); end
    compared++; if (obs_done !== 1) begin mismatched++; $display("FAIL rest_done: got %0d want 1", obs_done); end
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL rest_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
    clear_counts();
    load($urandom_range(1, 63), 0);
    compared++; if (done_with_note !== 1'b1 || busy !== 1'b0) begin mismatched++;
      $display("FAIL zero_dur: got done=%b busy=%b want done=1 busy=0", done_with_note, busy); end
    ticks(5);
    compared++; if (obs_gen !== 0 || obs_done !== 1) begin mismatched++;
      $display("FAIL zero_dur_after: got gen=%0d done=%0d want gen=0 done=1", obs_gen, obs_done); end
  endtask

  task automatic test_stall();
    clear_counts();
    do_reset();
    play_enable = 1;
    load(9, 10);
    ticks(2);
    rd_hold = 1;
    for (int i = 0; i < 30; i++) begin
      if (i % 10 == 0) new_sample_ready = 1;
      tick();
    end
    compared++; if (obs_gen !== 1) begin mismatched++; $display("FAIL stall_gen: got %0d want 1", obs_gen); end
    compared++; if (obs_ovr !== 2) begin mismatched++; $display("FAIL stall_overrun: got %0d want 2", obs_ovr); end
    compared++; if (obs_valid !== 0) begin mismatched++; $display("FAIL stall_valid: got %0d want 0", obs_valid); end
    rd_hold = 0;
    ticks(3);
    compared++; if (obs_valid !== 1 || sample_out !== last_ret) begin mismatched++;
      $display("FAIL stall_release: got valid=%0d out=%0d want valid=1 out=%0d", obs_valid, sample_out, last_ret); end
    new_sample_ready = 1; tick();
    compared++; if (generate_next !== 1'b1) begin mismatched++; $display("FAIL stall_cleared: got %b want 1", generate_next); end
    ticks(4);
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL stall_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask

  task automatic test_edges();
    int d0;
    clear_counts();
    do_reset();
    play_enable = 1;
    // final beat together with a strobe
    load(2, 1);
    ticks(2);
    beat = 1; new_sample_ready = 1; tick();
    compared++; if (done_with_note !== 1'b1 || generate_next !== 1'b0 || overrun !== 1'b0) begin mismatched++;
      $display("FAIL final_beat_strobe: got done=%b gen=%b ovr=%b want 1 0 0", done_with_note, generate_next, overrun); end
    tick();
    compared++; if (obs_gen !== 0 || obs_ovr !== 0) begin mismatched++;
      $display("FAIL final_beat_after: got gen=%0d ovr=%0d want 0 0", obs_gen, obs_ovr); end
    // load during PLAY is ignored
    load(3, 5);
    ticks(2);
    load(9, 1);
    compared++; if (rom_addr !== 6'd3 || busy !== 1'b1) begin mismatched++;
      $display("FAIL load_in_play: got addr=%0d busy=%b want 3 1", rom_addr, busy); end
    d0 = obs_done;
    beat = 1; tick();
    compared++; if (obs_done - d0 !== 0 || busy !== 1'b1) begin mismatched++;
      $display("FAIL load_in_play_beat: got done=%0d busy=%b want 0 1", obs_done - d0, busy); end
    // reset mid-note
    reset = 1; tick(); reset = 0;
    compared++; if ({busy, step_size, rom_addr, sample_out} !== '0) begin mismatched++;
      $display("FAIL reset_mid: got busy=%b step=%0d addr=%0d out=%0d want all 0", busy, step_size, rom_addr, sample_out); end
    ticks(5);
    compared++; if (obs_done - d0 !== 0) begin mismatched++; $display("FAIL reset_mid_done: got %0d want 0", obs_done - d0); end
    // load accepted in the done cycle
    load(4, 1);
    ticks(2);
    beat = 1; tick();
    load(0, 2);
    compared++; if (busy !== 1'b1 || step_size !== '0) begin mismatched++;
      $display("FAIL load_on_done: got busy=%b step=%0d want 1 0", busy, step_size); end
    ticks(3);
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL edges_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask

  task automatic test_random();
    clear_counts();
    do_reset();
    play_enable = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) play_enable = ~play_enable;
      if ($urandom_range(0, 39) == 0) rd_hold = ~rd_hold;
      rd_delay = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) begin
        note = NOTE_W'($urandom_range(0, 15));
        duration = DUR_W'($urandom_range(0, 3));
        load_new_note = 1;
      end
      if ($urandom_range(0, 11) == 0) beat = 1;
      if ($urandom_range(0, 5) == 0) new_sample_ready = 1;
      if (!sample_ready && !rd_pend && rd_cnt == 0 && $urandom_range(0, 29) == 0) begin
        sample_ready = 1;
        sample = SAMPLE_W'($urandom_range(1, 65535));
      end
      tick();
    end
    rd_hold = 0;
    ticks(8);
    compared++; if (trace_bad !== 0) begin mismatched++; $display("FAIL random_trace: cycle %0d got %h want %h", bad_cyc, bad_obs, bad_exp); end
    compared++; if (obs_gen !== exp_gen) begin mismatched++; $display("FAIL random_gen: got %0d want %0d", obs_gen, exp_gen); end
    compared++; if (obs_valid !== exp_valid) begin mismatched++; $display("FAIL random_valid: got %0d want %0d", obs_valid, exp_valid); end
    compared++; if (obs_done !== exp_done) begin mismatched++; $display("FAIL random_done: got %0d want %0d", obs_done, exp_done); end
    compared++; if (obs_ovr !== exp_ovr) begin mismatched++; $display("FAIL random_overrun: got %0d want %0d", obs_ovr, exp_ovr); end
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_play();
    test_pause();
    test_rest();
    test_stall();
    test_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
